// File: rtl/bsg_dff_pipe_reset_async_pkg.sv
// Shared helpers for the elastic reset-value register pipeline.
// Holds the sizing function for the occupancy counter.
package bsg_dff_pipe_reset_async_pkg;

    // Number of bits needed to count 0..depth occupied stages.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bsg_dff_en_reset_async.sv
// One pipeline stage: a valid bit that updates every cycle plus a data word
// that only loads when enabled. Both are cleared asynchronously.
module bsg_dff_en_reset_async #(
    parameter int                 width_p     = 16,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_q;
    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= reset_val_p;
        end else begin
            v_q <= v_i;
            if (en_i) data_q <= data_i;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_pipe_reset_async.sv
// Elastic depth_p-stage register pipeline with valid/yumi handshake, bubble
// collapsing, synchronous flush and occupancy count.
module bsg_dff_pipe_reset_async
    import bsg_dff_pipe_reset_async_pkg::*;
#(
    parameter int                 width_p     = 16,
    parameter int                 depth_p     = 2,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic [width_p-1:0]            data_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          yumi_i,
    output logic [cnt_width(depth_p)-1:0] count_o
);

    localparam int CntW = cnt_width(depth_p);

    logic [depth_p-1:0]              v_q, v_d, adv, ld;
    logic [depth_p-1:0][width_p-1:0] data_q, data_d;
    logic                            accept;

    // An item moves on when the slot ahead is empty or is itself moving.
    always_comb begin
        adv          = '0;
        adv[depth_p-1] = v_q[depth_p-1] & yumi_i;
        for (int k = depth_p - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
    end

    assign ready_o = ~flush_i & (~v_q[0] | adv[0]);
    assign accept  = valid_i & ready_o;

    // Flush clears valids only; data loads are suppressed so stages keep their words.
    always_comb begin
        ld        = '0;
        data_d    = data_q;
        ld[0]     = accept;
        data_d[0] = data_i;
        v_d[0]    = accept | (v_q[0] & ~adv[0]);
        for (int k = 1; k < depth_p; k++) begin
            ld[k]     = adv[k-1] & ~flush_i;
            data_d[k] = data_q[k-1];
            v_d[k]    = adv[k-1] | (v_q[k] & ~adv[k]);
        end
        if (flush_i) v_d = '0;
    end

    for (genvar k = 0; k < depth_p; k++) begin : g_stage
        bsg_dff_en_reset_async #(
            .width_p    (width_p),
            .reset_val_p(reset_val_p)
        ) u_stage (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .v_i      (v_d[k]),
            .en_i     (ld[k]),
            .data_i   (data_d[k]),
            .v_o      (v_q[k]),
            .data_o   (data_q[k])
        );
    end

    assign valid_o = v_q[depth_p-1];
    assign data_o  = data_q[depth_p-1];

    always_comb begin
        count_o = '0;
        for (int k = 0; k < depth_p; k++) begin
            count_o = count_o + CntW'(v_q[k]);
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> valid_o);
`endif

endmodule

// File: tb/tb_bsg_dff_pipe_reset_async.sv
// Bench for the elastic reset pipeline: directed scenarios plus a randomized
// run against a slot-compaction reference model.
module tb_bsg_dff_pipe_reset_async;

    localparam int          D  = 3;
    localparam logic [15:0] RV = 16'hA5A5;

    logic        clk_i = 1'b0;
    logic        reset_n_i, flush_i, valid_i, yumi_en, yumi_i;
    logic [15:0] data_i;
    logic        ready_o, valid_o;
    logic [15:0] data_o;
    logic [1:0]  count_o;

    int total = 0;
    int bad   = 0;

    bit   [D-1:0]       mv;
    logic [D-1:0][15:0] md;

    always #5 clk_i = ~clk_i;

    // Consumer only ever takes a presented item.
    assign yumi_i = yumi_en & valid_o;

    bsg_dff_pipe_reset_async #(.width_p(16), .depth_p(D), .reset_val_p(RV)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i),
        .count_o  (count_o)
    );

    task automatic drive(input bit vi, input logic [15:0] di, input bit ye, input bit fl);
        valid_i = vi; data_i = di; yumi_en = ye; flush_i = fl;
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        drive(0, 16'h0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        mv = '0;
        md = {D{RV}};
    endtask

    // Model: items slide forward one slot into any slot that is free after the
    // item ahead has moved; input enters slot 0 only if it ends up free.
    task automatic m_plan(input bit yi, input bit fl, output bit [D-1:0] nv,
                          output logic [D-1:0][15:0] nd, output bit rdy);
        nv = mv; nd = md;
        if (yi && nv[D-1]) nv[D-1] = 1'b0;
        for (int k = D - 2; k >= 0; k--) begin
            if (nv[k] && !nv[k+1]) begin
                nv[k+1] = 1'b1; nd[k+1] = nd[k]; nv[k] = 1'b0;
            end
        end
        rdy = !fl && !nv[0];
        if (fl) begin nv = '0; nd = md; end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        drive(0, 16'h0, 0, 0);
        @(negedge clk_i);
        total += 4;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", valid_o); end
        if (data_o !== RV) begin bad++; $display("FAIL reset_data got=%0h want=%0h", data_o, RV); end
        if (count_o !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", ready_o); end
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stream();
        int n = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(c < 8, 16'(c + 1), 1, 0);
            total++;
            if (ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready cyc=%0d got=%0h want=1", c, ready_o); end
            if (valid_o === 1'b1) begin
                total++;
                if (data_o !== 16'(n + 1) || c != 3 + n)
                    begin bad++; $display("FAIL stream_out got=%0h@%0d want=%0h@%0d", data_o, c, n + 1, 3 + n); end
                n++;
            end
            @(negedge clk_i);
        end
        total++;
        if (n != 8) begin bad++; $display("FAIL stream_count got=%0d want=8", n); end
    endtask

    task automatic test_stall();
        int acc = 0;
        int n = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1, 16'(16'h10 + c), 0, 0);
            if (ready_o === 1'b1) acc++;
            @(negedge clk_i);
        end
        drive(0, 16'h0, 0, 0);
        total += 3;
        if (acc != 3) begin bad++; $display("FAIL stall_accepted got=%0d want=3", acc); end
        if (ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0h want=0", ready_o); end
        if (count_o !== 2'd3) begin bad++; $display("FAIL stall_count got=%0d want=3", count_o); end
        drive(0, 16'h0, 1, 0);
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0h want=1", ready_o); end
        for (int c = 0; c < 6; c++) begin
            drive(0, 16'h0, 1, 0);
            if (valid_o === 1'b1) begin
                total++;
                if (data_o !== 16'(16'h10 + n)) begin bad++; $display("FAIL stall_drain got=%0h want=%0h", data_o, 16'h10 + n); end
                n++;
            end
            @(negedge clk_i);
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL stall_drain_count got=%0d want=3", n); end
    endtask

    task automatic test_bubbles();
        int n = 0;
        logic [15:0] exp_q [2];
        exp_q[0] = 16'h00B0; exp_q[1] = 16'h00B2;
        do_reset();
        drive(1, 16'h00B0, 0, 0); @(negedge clk_i);
        drive(0, 16'h0, 0, 0);    @(negedge clk_i);
        drive(1, 16'h00B2, 0, 0); @(negedge clk_i);
        for (int c = 0; c < 3; c++) begin drive(0, 16'h0, 0, 0); @(negedge clk_i); end
        drive(0, 16'h0, 0, 0);
        total += 4;
        if (count_o !== 2'd2) begin bad++; $display("FAIL bubble_count got=%0d want=2", count_o); end
        if (valid_o !== 1'b1) begin bad++; $display("FAIL bubble_valid got=%0h want=1", valid_o); end
        if (data_o !== 16'h00B0) begin bad++; $display("FAIL bubble_head got=%0h want=b0", data_o); end
        if (ready_o !== 1'b1) begin bad++; $display("FAIL bubble_ready got=%0h want=1", ready_o); end
        for (int c = 0; c < 4; c++) begin
            drive(0, 16'h0, 1, 0);
            if (valid_o === 1'b1) begin
                total++;
                if (n > 1 || data_o !== exp_q[n[0]]) begin bad++; $display("FAIL bubble_drain got=%0h idx=%0d", data_o, n); end
                n++;
            end
            @(negedge clk_i);
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL bubble_drain_count got=%0d want=2", n); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin drive(1, 16'(16'hC0 + c), 0, 0); @(negedge clk_i); end
        drive(1, 16'h00DD, 1, 1);
        total += 2;
        if (ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0h want=0", ready_o); end
        if (valid_o !== 1'b1) begin bad++; $display("FAIL flush_full got=%0h want=1", valid_o); end
        @(negedge clk_i);
        drive(0, 16'h0, 1, 0);
        total += 3;
        if (count_o !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", valid_o); end
        if (data_o !== 16'h00C0) begin bad++; $display("FAIL flush_data_hold got=%0h want=c0", data_o); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            drive(0, 16'h0, 1, 0);
            total++;
            if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_leak cyc=%0d got=%0h want=0", c, valid_o); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin drive(1, 16'(16'h50 + c), 1, 0); @(negedge clk_i); end
        drive(1, 16'h0055, 1, 0);
        total++;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%0h want=1", valid_o); end
        #1 reset_n_i = 1'b0;
        #1;
        total += 4;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0h want=0", valid_o); end
        if (count_o !== 2'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", count_o); end
        if (data_o !== RV) begin bad++; $display("FAIL areset_data got=%0h want=%0h", data_o, RV); end
        if (ready_o !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0h want=1", ready_o); end
        @(negedge clk_i);
        drive(0, 16'h0, 1, 0);
        reset_n_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            drive(0, 16'h0, 1, 0);
            total++;
            if (valid_o !== 1'b0 || count_o !== 2'd0)
                begin bad++; $display("FAIL areset_emerge cyc=%0d valid=%0h count=%0d want=0/0", c, valid_o, count_o); end
        end
    endtask

    task automatic test_random();
        bit   [D-1:0]       nv;
        logic [D-1:0][15:0] nd;
        bit                 rdy, vi, ye, fl;
        logic [15:0]        di;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vi = 1'($urandom_range(0, 1));
            ye = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 19) == 0);
            di = 16'($urandom);
            drive(vi, di, ye, fl);
            m_plan(ye & mv[D-1], fl, nv, nd, rdy);
            total += 4;
            if (ready_o !== rdy) begin bad++; $display("FAIL rand_ready i=%0d got=%0h want=%0h", i, ready_o, rdy); end
            if (valid_o !== mv[D-1]) begin bad++; $display("FAIL rand_valid i=%0d got=%0h want=%0h", i, valid_o, mv[D-1]); end
            if (count_o !== 2'($countones(mv))) begin bad++; $display("FAIL rand_count i=%0d got=%0d want=%0d", i, count_o, $countones(mv)); end
            if (data_o !== md[D-1]) begin bad++; $display("FAIL rand_data i=%0d got=%0h want=%0h", i, data_o, md[D-1]); end
            if (vi && rdy) begin nv[0] = 1'b1; nd[0] = di; end
            @(negedge clk_i);
            mv = nv; md = nd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n_i = 1'b0;
        valid_i = 1'b0; data_i = 16'h0; yumi_en = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
